// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared state type, LED constants and round-robin pick for led_bank_arbiter
package led_arb_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} arb_state_e;

    localparam int NUM_LEDS = 8;
    localparam logic [NUM_LEDS-1:0] LED_OFF = 8'hFF;

    // First set bit of req at or above start, wrapping at n; returns start when req is empty.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start,
                                           input int unsigned n);
        logic        found;
        logic [2:0]  pick;
        int unsigned idx;
        found = 1'b0;
        pick  = start;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(start) + i) % n;
            if (i < n && !found && req[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks
module led_tick_gen #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic CLK_50,
    input  logic RESET_N,
    output logic tick
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin owner of the active-low LED bank: show pattern, then dark gap
// Optional blinking during SHOW is built when LED_ARB_BLINK_EN is defined.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned HOLD_MS  = 500,
    parameter int unsigned GAP_MS   = 100,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic                   CLK_50,
    input  logic                   RESET_N,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [8*NUM_REQ-1:0]   PATTERN,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [NUM_REQ-1:0]     DONE,
    output logic                   BUSY,
    output logic [NUM_LEDS-1:0]    LED
);
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MS - 1);

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                tick;
    logic                lit;
    logic [7:0]          req_ext;
    logic [PW-1:0]       win_idx;
    logic [NUM_LEDS-1:0] win_pattern;

    led_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .CLK_50 (CLK_50),
        .RESET_N(RESET_N),
        .tick   (tick)
    );

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = REQ;
        win_idx = PW'(rr_pick(req_ext, 3'(ptr_q), NUM_REQ));
        win_pattern = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_pattern = PATTERN[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    state_d   = SHOW;
                    owner_d   = win_idx;
                    pattern_d = win_pattern;
                    cnt_d     = '0;
                    ptr_d     = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end
            SHOW: begin
                // Expiry wins over a simultaneous REQ drop so the owner still sees DONE.
                if (tick && cnt_q == HOLD_LAST) begin
                    state_d         = GAP;
                    cnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                end else if (!REQ[owner_q]) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            pattern_q <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

`ifdef LED_ARB_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_on_q, blink_on_d;

    // Held at "lit, count 0" outside SHOW so every grant starts lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (state_q != SHOW) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign lit = blink_on_q;
`else
    logic unused_blink_ms;
    assign unused_blink_ms = ^BLINK_MS;
    assign lit = 1'b1;
`endif

    always_comb begin
        GRANT = '0;
        if (state_q == SHOW) begin
            GRANT[owner_q] = 1'b1;
        end
    end

    assign DONE = done_q;
    assign BUSY = (state_q != IDLE);
    assign LED  = (state_q == SHOW && lit) ? ~pattern_q : LED_OFF;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - scoreboard bench for led_bank_arbiter (tick every 10 clk, HOLD 3, GAP 2)
module tb_led_bank_arbiter;
    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] led;
    } gexp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] pattern;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  led;

    int checks      = 0;
    int errors      = 0;
    int grants_seen = 0;
    int dones_seen  = 0;
    int cyc         = 0;

    gexp_t      exp_grant_q[$];
    logic [3:0] exp_done_q[$];

    led_bank_arbiter #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .NUM_REQ (4),
        .HOLD_MS (3),
        .GAP_MS  (2),
        .BLINK_MS(1)
    ) dut (
        .CLK_50 (clk),
        .RESET_N(rst_n),
        .REQ    (req),
        .PATTERN(pattern),
        .GRANT  (grant),
        .DONE   (done),
        .BUSY   (busy),
        .LED    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic push_g(input logic [3:0] g, input logic [7:0] l);
        exp_grant_q.push_back({g, l});
    endtask

    task automatic wait_grants(input int target, input int budget);
        int k;
        k = 0;
        while (grants_seen < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (grants_seen < target) begin
            checks++;
            errors++;
            $display("FAIL wait_grant act=%0d exp=%0d", grants_seen, target);
        end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k;
        k = 0;
        while (dones_seen < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (dones_seen < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done act=%0d exp=%0d", dones_seen, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle act=%0b exp=0", busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a new grant or a DONE pulse appears.
    initial begin
        logic [3:0] prev_grant;
        int         grant_cyc;
        int         done_cyc;
        bit         gap_armed;
        gexp_t      ge;
        logic [3:0] de;
        prev_grant = '0;
        grant_cyc  = 0;
        done_cyc   = 0;
        gap_armed  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_grant = '0;
                gap_armed  = 1'b0;
            end else begin
                if (grant != 4'b0 && grant != prev_grant) begin
                    grants_seen++;
                    grant_cyc = cyc;
                    if (exp_grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant act=%b exp=none", grant);
                    end else begin
                        ge = exp_grant_q.pop_front();
                        chk("grant", 32'(grant), 32'(ge.grant));
                        chk("grant_led", 32'(led), 32'(ge.led));
                        chk("grant_busy", 32'(busy), 1);
                    end
                end
                if (done != 4'b0) begin
                    dones_seen++;
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done act=%b exp=none", done);
                    end else begin
                        de = exp_done_q.pop_front();
                        chk("done", 32'(done), 32'(de));
                        chk_rng("hold_clks", cyc - grant_cyc, 20, 30);
                        chk("done_grant", 32'(grant), 0);
                        chk("done_led", 32'(led), 'hFF);
                    end
                    done_cyc  = cyc;
                    gap_armed = 1'b1;
                end else if (gap_armed && !busy) begin
                    chk_rng("gap_clks", cyc - done_cyc, 10, 20);
                    gap_armed = 1'b0;
                end
                prev_grant = grant;
            end
        end
    end

    initial begin
        int         tgt;
        int         changes;
        int         t1;
        int         t2;
        int         k;
        int         bad;
        logic [7:0] last;

        rst_n   = 1'b0;
        req     = 4'hF;
        pattern = 32'h88442211;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 'hFF);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);

        // Fairness: all four requesting, rotation 0,1,2,3,0.
        push_g(4'b0001, 8'hEE);
        push_g(4'b0010, 8'hDD);
        push_g(4'b0100, 8'hBB);
        push_g(4'b1000, 8'h77);
        push_g(4'b0001, 8'hEE);
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0100);
        exp_done_q.push_back(4'b1000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_grant", 32'(grant), 'b0001);
        wait_grants(5, 400);
        req = 4'h0;
        wait_idle(60);
        chk("fair_dones", 32'(dones_seen), 4);

        // Single requester with latched pattern.
        pattern = 32'h00A50000;
        push_g(4'b0100, 8'h5A);
        exp_done_q.push_back(4'b0100);
        tgt = dones_seen + 1;
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("single_grant", 32'(grant), 'b0100);
        chk("single_led", 32'(led), 'h5A);
        pattern[23:16] = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("latched_led", 32'(led), 'h5A);
        wait_dones(tgt, 60);
        req = 4'h0;
        wait_idle(60);

        // Abandon: pointer at 3, so requester 1 wins after wrapping.
        pattern = 32'h00008100;
        push_g(4'b0010, 8'h7E);
        req = 4'b0010;
        @(posedge clk);
        #1;
        chk("abandon_grant", 32'(grant), 'b0010);
        repeat (4) @(posedge clk);
        #1;
        req = 4'h0;
        @(posedge clk);
        #1;
        chk("abandon_grant_off", 32'(grant), 0);
        chk("abandon_led", 32'(led), 'hFF);
        chk("abandon_busy", 32'(busy), 1);
        chk("abandon_done", 32'(done), 0);
        wait_idle(60);

        // Reset mid-SHOW: pointer would be 1 afterwards, reset must return it to 0.
        pattern = 32'h000000C3;
        push_g(4'b0001, 8'h3C);
        req = 4'b0001;
        @(posedge clk);
        #1;
        chk("pre_rst_grant", 32'(grant), 'b0001);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 'hFF);
        chk("async_rst_grant", 32'(grant), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        req = 4'hF;
        push_g(4'b0001, 8'h3C);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ptr_grant", 32'(grant), 'b0001);
        req = 4'h0;
        wait_idle(60);

        // LED behaviour through a full SHOW (blinking or steady by build).
        pattern = 32'h0000000F;
        push_g(4'b0001, 8'hF0);
        exp_done_q.push_back(4'b0001);
        req = 4'b0001;
        @(posedge clk);
        #1;
        chk("show_grant", 32'(grant), 'b0001);
        changes = 0;
        t1      = 0;
        t2      = 0;
        k       = 0;
        bad     = 0;
        last    = led;
        while (grant != 4'b0 && k < 60) begin
`ifdef LED_ARB_BLINK_EN
            if (led !== 8'hF0 && led !== 8'hFF) bad++;
`else
            if (led !== 8'hF0) bad++;
`endif
            if (led !== last) begin
                changes++;
                if (changes == 1) t1 = k;
                if (changes == 2) t2 = k;
                last = led;
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk("show_ended", 32'(k < 60), 1);
        chk("show_led_vals", 32'(bad), 0);
`ifdef LED_ARB_BLINK_EN
        chk("blink_changes", 32'(changes >= 2), 1);
        chk("blink_period", 32'(t2 - t1), 10);
`else
        chk("steady_changes", 32'(changes), 0);
`endif
        req = 4'h0;
        wait_idle(60);

        repeat (5) @(posedge clk);
        #1;
        chk("grant_q_empty", 32'(exp_grant_q.size()), 0);
        chk("done_q_empty", 32'(exp_done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
